// File: rtl/arv_pkg.sv
// Front-end fetch types: stage control structs, FSM states, PC mux selects
// and the I-cache line alignment helper.
package arv_pkg;

  import riscv_pkg::*;

  localparam int FETCH_LINE_BYTES = 16;

  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_MISS   = 2'd2,
    FETCH_REPLAY = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INCR = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic                     stall;
    logic                     flush;
    logic [PHY_ADDR_SIZE-1:0] pc;
  } fetch_1_ctrl_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } fetch_2_ctrl_t;

  // Clear the byte-within-line offset so the address names a whole line.
  function automatic logic [PHY_ADDR_SIZE-1:0] line_align(input logic [PHY_ADDR_SIZE-1:0] addr);
    logic [PHY_ADDR_SIZE-1:0] offset_mask;
    offset_mask = PHY_ADDR_SIZE'(FETCH_LINE_BYTES - 1);
    return addr & ~offset_mask;
  endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Core-wide architectural constants shared by the front end.
package riscv_pkg;

  localparam int PHY_ADDR_SIZE = 32;

endpackage

// File: rtl/fetch_pc_gen.sv
// Architectural fetch PC register. The controller picks hold, sequential
// increment (wrapping modulo 2^PHY_ADDR_SIZE) or load of an explicit target.
module fetch_pc_gen
  import riscv_pkg::*, arv_pkg::*;
#(
  parameter logic [PHY_ADDR_SIZE-1:0] BOOT_ADDR   = 32'h8000_0000,
  parameter int                       INSTR_BYTES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  pc_sel_e                  pc_sel_i,
  input  logic [PHY_ADDR_SIZE-1:0] load_pc_i,
  output logic [PHY_ADDR_SIZE-1:0] pc_o
);

  logic [PHY_ADDR_SIZE-1:0] pc_q;
  logic [PHY_ADDR_SIZE-1:0] pc_d;

  // Next-PC mux; the adder simply overflows to give the wrap-around.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_i)
      PC_INCR: pc_d = pc_q + PHY_ADDR_SIZE'(INSTR_BYTES);
      PC_LOAD: pc_d = load_pc_i;
      default: pc_d = pc_q;
    endcase
  end

  // PC register, returns to the boot vector on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= BOOT_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end sequencing controller: owns the fetch PC, stalls/flushes the
// two fetch stages, arbitrates redirects against decode backpressure and
// I-cache misses, and drives the refill request/acknowledge handshake.
module fetch_ctrl
  import riscv_pkg::*, arv_pkg::*;
#(
  parameter logic [PHY_ADDR_SIZE-1:0] BOOT_ADDR   = 32'h8000_0000,
  parameter int                       INSTR_BYTES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_valid_i,
  input  logic [PHY_ADDR_SIZE-1:0] redirect_pc_i,
  input  logic                     decode_ready_i,
  input  logic                     f2_valid_i,
  input  logic                     f2_hit_i,
  input  logic [PHY_ADDR_SIZE-1:0] f2_pc_i,
  output logic                     refill_req_o,
  output logic [PHY_ADDR_SIZE-1:0] refill_addr_o,
  input  logic                     refill_ack_i,
  output fetch_1_ctrl_t            fetch_1_ctrl_o,
  output fetch_2_ctrl_t            fetch_2_ctrl_o,
  output logic [1:0]               state_o
);

  fetch_state_e             state_q, state_d;
  logic                     stall_q, stall_d;
  logic                     refill_req_q, refill_req_d;
  logic [PHY_ADDR_SIZE-1:0] refill_addr_q, refill_addr_d;
  logic                     pend_redirect_q, pend_redirect_d;
  logic [PHY_ADDR_SIZE-1:0] pend_pc_q, pend_pc_d;

  pc_sel_e                  pc_sel;
  logic [PHY_ADDR_SIZE-1:0] pc_load;
  logic [PHY_ADDR_SIZE-1:0] pc;
  logic                     flush_1;
  logic                     flush_2;

  fetch_pc_gen #(
    .BOOT_ADDR   (BOOT_ADDR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pc_sel_i  (pc_sel),
    .load_pc_i (pc_load),
    .pc_o      (pc)
  );

  // Next-state, PC selection, refill handshake and combinational flushes.
  always_comb begin
    state_d         = state_q;
    stall_d         = stall_q;
    refill_req_d    = refill_req_q;
    refill_addr_d   = refill_addr_q;
    pend_redirect_d = pend_redirect_q;
    pend_pc_d       = pend_pc_q;
    pc_sel          = PC_HOLD;
    pc_load         = redirect_pc_i;
    flush_1         = 1'b0;
    flush_2         = 1'b0;

    case (state_q)
      FETCH_BOOT: begin
        // PC already sits at the boot vector; just release the stages.
        stall_d = 1'b0;
        state_d = FETCH_RUN;
      end

      FETCH_RUN, FETCH_REPLAY: begin
        // REPLAY drops whatever fetch_2 holds so the missed PC re-looks-up.
        if (state_q == FETCH_REPLAY) begin
          flush_2 = 1'b1;
        end
        state_d = FETCH_RUN;
        if (redirect_valid_i) begin
          pc_sel  = PC_LOAD;
          pc_load = redirect_pc_i;
          flush_1 = 1'b1;
          flush_2 = 1'b1;
          stall_d = 1'b0;
        end else if (state_q == FETCH_RUN && f2_valid_i && !f2_hit_i) begin
          // Rewind to the missed PC and hold both stages until the refill.
          state_d       = FETCH_MISS;
          refill_req_d  = 1'b1;
          refill_addr_d = line_align(f2_pc_i);
          pc_sel        = PC_LOAD;
          pc_load       = f2_pc_i;
          stall_d       = 1'b1;
        end else if (!decode_ready_i) begin
          stall_d = 1'b1;
        end else begin
          pc_sel  = PC_INCR;
          stall_d = 1'b0;
        end
      end

      FETCH_MISS: begin
        stall_d = 1'b1;
        // Redirects cannot abort the refill; remember the newest one.
        if (redirect_valid_i) begin
          pend_redirect_d = 1'b1;
          pend_pc_d       = redirect_pc_i;
        end
        if (refill_ack_i) begin
          refill_req_d    = 1'b0;
          pend_redirect_d = 1'b0;
          stall_d         = 1'b0;
          if (redirect_valid_i || pend_redirect_q) begin
            pc_sel  = PC_LOAD;
            pc_load = redirect_valid_i ? redirect_pc_i : pend_pc_q;
            flush_1 = 1'b1;
            flush_2 = 1'b1;
            state_d = FETCH_RUN;
          end else begin
            state_d = FETCH_REPLAY;
          end
        end
      end

      default: begin
        state_d = FETCH_BOOT;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= FETCH_BOOT;
      stall_q         <= 1'b1;
      refill_req_q    <= 1'b0;
      refill_addr_q   <= '0;
      pend_redirect_q <= 1'b0;
      pend_pc_q       <= '0;
    end else begin
      state_q         <= state_d;
      stall_q         <= stall_d;
      refill_req_q    <= refill_req_d;
      refill_addr_q   <= refill_addr_d;
      pend_redirect_q <= pend_redirect_d;
      pend_pc_q       <= pend_pc_d;
    end
  end

  // Flushes are forced while reset is held so the stages never see junk.
  assign fetch_1_ctrl_o = '{stall: stall_q, flush: flush_1 | rst_i, pc: pc};
  assign fetch_2_ctrl_o = '{stall: stall_q, flush: flush_2 | rst_i};
  assign refill_req_o   = refill_req_q;
  assign refill_addr_o  = refill_addr_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. A negedge monitor pops the expected
// issued-PC stream (pushed by the scenario tasks) whenever fetch_1 is unstalled.
module tb_fetch_ctrl;

  import riscv_pkg::*;
  import arv_pkg::*;

  logic                     clk_i;
  logic                     rst_i;
  logic                     redirect_valid_i;
  logic [PHY_ADDR_SIZE-1:0] redirect_pc_i;
  logic                     decode_ready_i;
  logic                     f2_valid_i;
  logic                     f2_hit_i;
  logic [PHY_ADDR_SIZE-1:0] f2_pc_i;
  logic                     refill_req_o;
  logic [PHY_ADDR_SIZE-1:0] refill_addr_o;
  logic                     refill_ack_i;
  fetch_1_ctrl_t            fetch_1_ctrl_o;
  fetch_2_ctrl_t            fetch_2_ctrl_o;
  logic [1:0]               state_o;

  int pass_cnt  = 0;
  int check_cnt = 0;
  bit mon_en    = 0;
  logic [31:0] exp_q[$];

  fetch_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .decode_ready_i   (decode_ready_i),
    .f2_valid_i       (f2_valid_i),
    .f2_hit_i         (f2_hit_i),
    .f2_pc_i          (f2_pc_i),
    .refill_req_o     (refill_req_o),
    .refill_addr_o    (refill_addr_o),
    .refill_ack_i     (refill_ack_i),
    .fetch_1_ctrl_o   (fetch_1_ctrl_o),
    .fetch_2_ctrl_o   (fetch_2_ctrl_o),
    .state_o          (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard: every unstalled fetch_1 cycle must match the next expected PC.
  always @(negedge clk_i) begin
    if (mon_en && !rst_i && !fetch_1_ctrl_o.stall) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL issue_pc: got unexpected issue of %08h, want no issue", fetch_1_ctrl_o.pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fetch_1_ctrl_o.pc !== e) begin
          $display("FAIL issue_pc: got %08h want %08h", fetch_1_ctrl_o.pc, e);
        end else begin
          pass_cnt++;
          $display("issue pc=%08h ok", e);
        end
      end
    end
  end

  // Advance one cycle; optionally record the PC expected to issue in it.
  task automatic step(input logic [31:0] pc, input bit issue);
    @(posedge clk_i);
    #1;
    if (issue) exp_q.push_back(pc);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    redirect_valid_i = 1'b0; redirect_pc_i = '0; decode_ready_i = 1'b1;
    f2_valid_i = 1'b0; f2_hit_i = 1'b1; f2_pc_i = '0; refill_ack_i = 1'b0;
    step(32'h0, 0);
    step(32'h0, 0);
    #1;
    check_cnt++;
    if (state_o !== 2'd0 || fetch_1_ctrl_o.pc !== 32'h8000_0000 || refill_req_o !== 1'b0 || refill_addr_o !== 32'h0)
      $display("FAIL reset_regs: got state=%0d pc=%08h req=%b addr=%08h want 0/80000000/0/00000000",
               state_o, fetch_1_ctrl_o.pc, refill_req_o, refill_addr_o);
    else pass_cnt++;
    check_cnt++;
    if ({fetch_1_ctrl_o.stall, fetch_2_ctrl_o.stall, fetch_1_ctrl_o.flush, fetch_2_ctrl_o.flush} !== 4'b1111)
      $display("FAIL reset_ctrl: got stall/flush=%b want 1111",
               {fetch_1_ctrl_o.stall, fetch_2_ctrl_o.stall, fetch_1_ctrl_o.flush, fetch_2_ctrl_o.flush});
    else pass_cnt++;
    rst_i  = 1'b0;
    mon_en = 1'b1;
    #1;
    check_cnt++;
    if (state_o !== 2'd0 || fetch_1_ctrl_o.flush !== 1'b0 || fetch_2_ctrl_o.flush !== 1'b0)
      $display("FAIL boot_cycle: got state=%0d flush=%b%b want 0 flush=00", state_o,
               fetch_1_ctrl_o.flush, fetch_2_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0000, 1);
    #1;
    check_cnt++;
    if (state_o !== 2'd1 || fetch_1_ctrl_o.stall !== 1'b0 || fetch_1_ctrl_o.flush !== 1'b0)
      $display("FAIL boot_to_run: got state=%0d stall=%b flush=%b want 1 0 0", state_o,
               fetch_1_ctrl_o.stall, fetch_1_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0004, 1);
    step(32'h8000_0008, 1);
    $display("reset/boot sequence done");
  endtask

  task automatic test_redirect;
    step(32'h8000_000C, 1);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    #1;
    check_cnt++;
    if (fetch_1_ctrl_o.flush !== 1'b1 || fetch_2_ctrl_o.flush !== 1'b1)
      $display("FAIL redirect_flush: got %b%b want 11", fetch_1_ctrl_o.flush, fetch_2_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0100, 1);
    redirect_valid_i = 1'b0;
    #1;
    check_cnt++;
    if (fetch_1_ctrl_o.flush !== 1'b0 || fetch_2_ctrl_o.flush !== 1'b0)
      $display("FAIL redirect_unflush: got %b%b want 00", fetch_1_ctrl_o.flush, fetch_2_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0104, 1);
    $display("redirect to 80000100 done");
  endtask

  task automatic test_miss;
    step(32'h8000_0108, 1);
    f2_valid_i = 1'b1; f2_hit_i = 1'b0; f2_pc_i = 32'h8000_0024;
    #1;
    check_cnt++;
    if (refill_req_o !== 1'b0)
      $display("FAIL miss_req_early: got %b want 0", refill_req_o);
    else pass_cnt++;
    step(32'h0, 0);
    f2_valid_i = 1'b0; f2_hit_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_cnt++;
      if (state_o !== 2'd2 || refill_req_o !== 1'b1 || refill_addr_o !== 32'h8000_0020 ||
          fetch_1_ctrl_o.stall !== 1'b1 || fetch_2_ctrl_o.stall !== 1'b1)
        $display("FAIL miss_hold: got state=%0d req=%b addr=%08h stall=%b%b want 2 1 80000020 11",
                 state_o, refill_req_o, refill_addr_o, fetch_1_ctrl_o.stall, fetch_2_ctrl_o.stall);
      else pass_cnt++;
      step(32'h0, 0);
    end
    refill_ack_i = 1'b1;
    #1;
    check_cnt++;
    if (refill_req_o !== 1'b1 || fetch_1_ctrl_o.flush !== 1'b0)
      $display("FAIL miss_ack_cycle: got req=%b flush=%b want 1 0", refill_req_o, fetch_1_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0024, 1);
    refill_ack_i = 1'b0;
    #1;
    check_cnt++;
    if (state_o !== 2'd3 || refill_req_o !== 1'b0 || fetch_2_ctrl_o.flush !== 1'b1 || fetch_1_ctrl_o.flush !== 1'b0)
      $display("FAIL replay: got state=%0d req=%b flush1=%b flush2=%b want 3 0 0 1",
               state_o, refill_req_o, fetch_1_ctrl_o.flush, fetch_2_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0028, 1);
    #1;
    check_cnt++;
    if (state_o !== 2'd1)
      $display("FAIL replay_to_run: got state=%0d want 1", state_o);
    else pass_cnt++;
    $display("miss at 80000024 refilled and replayed");
  endtask

  task automatic test_miss_redirect;
    step(32'h8000_002C, 1);
    f2_valid_i = 1'b1; f2_hit_i = 1'b0; f2_pc_i = 32'h8000_0044;
    step(32'h0, 0);
    f2_valid_i = 1'b0; f2_hit_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    #1;
    check_cnt++;
    if (fetch_1_ctrl_o.flush !== 1'b0 || refill_addr_o !== 32'h8000_0040)
      $display("FAIL miss_redir_latch: got flush=%b addr=%08h want 0 80000040",
               fetch_1_ctrl_o.flush, refill_addr_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step(32'h0, 0);
      redirect_valid_i = 1'b0;
      #1;
      check_cnt++;
      if (refill_req_o !== 1'b1 || state_o !== 2'd2)
        $display("FAIL miss_redir_hold: got req=%b state=%0d want 1 2", refill_req_o, state_o);
      else pass_cnt++;
    end
    step(32'h0, 0);
    refill_ack_i = 1'b1;
    #1;
    check_cnt++;
    if (refill_req_o !== 1'b1 || fetch_1_ctrl_o.flush !== 1'b1 || fetch_2_ctrl_o.flush !== 1'b1)
      $display("FAIL miss_redir_ack: got req=%b flush=%b%b want 1 11", refill_req_o,
               fetch_1_ctrl_o.flush, fetch_2_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0200, 1);
    refill_ack_i = 1'b0;
    #1;
    check_cnt++;
    if (state_o !== 2'd1 || refill_req_o !== 1'b0)
      $display("FAIL miss_redir_run: got state=%0d req=%b want 1 0", state_o, refill_req_o);
    else pass_cnt++;
    step(32'h8000_0204, 1);
    $display("pending redirect to 80000200 taken after refill");
  endtask

  task automatic test_stall;
    step(32'h8000_0208, 1);
    decode_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 0);
      if (i == 2) decode_ready_i = 1'b1;
      #1;
      check_cnt++;
      if (fetch_1_ctrl_o.stall !== 1'b1 || fetch_2_ctrl_o.stall !== 1'b1 || fetch_1_ctrl_o.pc !== 32'h8000_0208)
        $display("FAIL stall_hold: got stall=%b%b pc=%08h want 11 80000208",
                 fetch_1_ctrl_o.stall, fetch_2_ctrl_o.stall, fetch_1_ctrl_o.pc);
      else pass_cnt++;
    end
    step(32'h8000_020C, 1);
    $display("decode backpressure released");
  endtask

  task automatic test_back_to_back;
    step(32'h8000_0210, 1);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0300;
    step(32'h8000_0300, 1);
    redirect_pc_i = 32'h8000_0400;
    #1;
    check_cnt++;
    if (fetch_1_ctrl_o.flush !== 1'b1)
      $display("FAIL b2b_flush: got %b want 1", fetch_1_ctrl_o.flush);
    else pass_cnt++;
    step(32'h8000_0400, 1);
    redirect_pc_i = 32'hFFFF_FFFC;
    step(32'hFFFF_FFFC, 1);
    redirect_valid_i = 1'b0;
    step(32'h0000_0000, 1);
    $display("back-to-back redirects and PC wrap done");
  endtask

  task automatic test_reset_mid_miss;
    step(32'h0000_0004, 1);
    f2_valid_i = 1'b1; f2_hit_i = 1'b0; f2_pc_i = 32'h8000_0050;
    step(32'h0, 0);
    f2_valid_i = 1'b0; f2_hit_i = 1'b1;
    #1;
    check_cnt++;
    if (refill_req_o !== 1'b1 || refill_addr_o !== 32'h8000_0050)
      $display("FAIL mid_miss_req: got req=%b addr=%08h want 1 80000050", refill_req_o, refill_addr_o);
    else pass_cnt++;
    rst_i = 1'b1;
    #1;
    check_cnt++;
    if (refill_req_o !== 1'b0 || state_o !== 2'd0 || fetch_1_ctrl_o.pc !== 32'h8000_0000)
      $display("FAIL async_reset: got req=%b state=%0d pc=%08h want 0 0 80000000",
               refill_req_o, state_o, fetch_1_ctrl_o.pc);
    else pass_cnt++;
    step(32'h0, 0);
    rst_i = 1'b0;
    step(32'h8000_0000, 1);
    step(32'h8000_0004, 1);
    #1;
    check_cnt++;
    if (state_o !== 2'd1)
      $display("FAIL post_reset_run: got state=%0d want 1", state_o);
    else pass_cnt++;
    $display("reset during miss recovered");
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_miss();
    test_miss_redirect();
    test_stall();
    test_back_to_back();
    test_reset_mid_miss();
    @(negedge clk_i);
    #1;
    mon_en = 1'b0;
    check_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL issue_drain: got %0d unissued PCs want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
